// File: rtl/key_num_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_num_pkg
// Description : Shared types and constants for the keyboard number-entry
//               block. Provides the key classification enum, the entry state
//               enum and the ASCII control codes recognised by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package key_num_pkg;

  // Classification of a released key
  typedef enum logic [2:0] {
    KC_DIGIT   = 3'd0,
    KC_BKSP    = 3'd1,
    KC_ENTER   = 3'd2,
    KC_ESC     = 3'd3,
    KC_MINUS   = 3'd4,
    KC_INVALID = 3'd5
  } key_class_t;

  // Entry state: IDLE holds no digits, ENTRY holds at least one
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_BKSP  = 8'h08;
  localparam logic [7:0] ASCII_ENTER = 8'h0D;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  // True for 'a'-'f' or 'A'-'F'
  function automatic logic is_hex_letter(input logic [7:0] code);
    return ((code >= 8'h61) && (code <= 8'h66)) ||
           ((code >= 8'h41) && (code <= 8'h46));
  endfunction

endpackage : key_num_pkg
`default_nettype wire

// File: rtl/key_ascii_decode.sv
`default_nettype none
// ============================================================================
// Module      : key_ascii_decode
// Description : Combinational ASCII key classifier. Maps '0'-'9' to digits
//               0-9, 'a'-'f'/'A'-'F' to digits 10-15 (hex mode only), and
//               recognises backspace, enter, escape and minus. Anything else
//               is classified as invalid.
// Revision    : 1.0 - initial release
// Ports       :
//   key_ascii_i  in  8  ASCII code of the released key
//   dec_i        in  1  1 = decimal mode (hex letters are invalid)
//   key_class_o  out    key classification
//   digit_o      out 4  digit value, meaningful only for KC_DIGIT
// ============================================================================
module key_ascii_decode
  import key_num_pkg::*;
(
  input  logic [7:0] key_ascii_i,
  input  logic       dec_i,
  output key_class_t key_class_o,
  output logic [3:0] digit_o
);

  always_comb begin
    key_class_o = KC_INVALID;
    digit_o     = 4'd0;
    if ((key_ascii_i >= 8'h30) && (key_ascii_i <= 8'h39)) begin
      key_class_o = KC_DIGIT;
      digit_o     = key_ascii_i[3:0];
    end else if (is_hex_letter(key_ascii_i)) begin
      // Low nibble of 'a'/'A' is 1, so adding 9 yields 10..15
      if (!dec_i) begin
        key_class_o = KC_DIGIT;
        digit_o     = key_ascii_i[3:0] + 4'd9;
      end
    end else begin
      unique case (key_ascii_i)
        ASCII_BKSP:  key_class_o = KC_BKSP;
        ASCII_ENTER: key_class_o = KC_ENTER;
        ASCII_ESC:   key_class_o = KC_ESC;
        ASCII_MINUS: key_class_o = KC_MINUS;
        default:     key_class_o = KC_INVALID;
      endcase
    end
  end

endmodule : key_ascii_decode
`default_nettype wire

// File: rtl/key_num_entry.sv
`default_nettype none
// ============================================================================
// Module      : key_num_entry
// Description : Accumulates digits typed on a PS/2 keyboard into a binary
//               number (hex or decimal), with backspace, escape (clear) and
//               enter (commit). One event is taken per key release, detected
//               on the falling edge of a 2-flop synchronised key_state.
//               Outputs update 3 clk after the key_state pin falls.
// Revision    : 1.0 - initial release
// Options     : KEY_NUM_SIGN_EN - adds a '-' prefix and the neg output; the
//               committed value is then the two's complement when neg is set.
// Ports       :
//   clk        in            system clock
//   reset      in            asynchronous active-high reset
//   key_state  in   1        high while a key is held (asynchronous)
//   key_ascii  in   8        ASCII code of the current/last key
//   radix_dec  in   1        1 = decimal, 0 = hex; sampled at the first digit
//   edit_num   out  DATA_W   value being typed
//   final_num  out  DATA_W   last committed value
//   digit_cnt  out  CNT_W    digits held in edit_num
//   num_valid  out  1        1-clk pulse on commit
//   err        out  1        1-clk pulse on a rejected key
//   neg        out  1        negative flag (KEY_NUM_SIGN_EN only)
// ============================================================================
module key_num_entry
  import key_num_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int MAX_DIGITS = 8,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_state,
  input  logic [7:0]        key_ascii,
  input  logic              radix_dec,
  output logic [DATA_W-1:0] edit_num,
  output logic [DATA_W-1:0] final_num,
  output logic [CNT_W-1:0]  digit_cnt,
  output logic              num_valid,
  output logic              err
`ifdef KEY_NUM_SIGN_EN
  ,
  output logic              neg
`endif
);

  if (DATA_W < 4 * MAX_DIGITS) begin : g_width_check
    $error("key_num_entry: DATA_W must be at least 4*MAX_DIGITS");
  end

  localparam logic [DATA_W+3:0] C_TEN_WIDE = (DATA_W + 4)'(10);
  localparam logic [DATA_W-1:0] C_TEN      = DATA_W'(10);
  localparam logic [CNT_W-1:0]  C_MAX_CNT  = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]  C_ONE_CNT  = CNT_W'(1);

  // Registered state
  state_t            state_q;
  logic              radix_q;     // latched radix, 1 = decimal
  logic [DATA_W-1:0] edit_q;
  logic [DATA_W-1:0] final_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic              err_q;
  logic              neg_q;
  logic              ks_meta_q;
  logic              ks_sync_q;
  logic              ks_prev_q;

  // Combinational next values for the datapath
  logic              key_event_w;
  logic              dec_mode_w;
  key_class_t        key_class_w;
  logic [3:0]        digit_w;
  logic [DATA_W+3:0] prod_w;
  logic [DATA_W-1:0] edit_append_d;
  logic [DATA_W-1:0] edit_bksp_d;
  logic [DATA_W-1:0] final_commit_d;
  logic [3:0]        unused_prod_hi;

  // Release = synchronised key_state went 1 -> 0
  assign key_event_w = ks_prev_q & ~ks_sync_q;

  // In IDLE the live radix pin decides letter validity; in ENTRY the latch does
  assign dec_mode_w = (state_q == ST_IDLE) ? radix_dec : radix_q;

  key_ascii_decode u_decode (
    .key_ascii_i (key_ascii),
    .dec_i       (dec_mode_w),
    .key_class_o (key_class_w),
    .digit_o     (digit_w)
  );

  // The width check bounds edit_q below R^MAX_DIGITS, so the product never
  // reaches the top four bits and truncation loses nothing.
  always_comb begin
    prod_w = radix_q ? ({4'd0, edit_q} * C_TEN_WIDE) : {edit_q, 4'd0};
    prod_w = prod_w + (DATA_W + 4)'(digit_w);
  end

  assign edit_append_d  = prod_w[DATA_W-1:0];
  assign unused_prod_hi = prod_w[DATA_W+3:DATA_W];
  assign edit_bksp_d    = radix_q ? (edit_q / C_TEN) : (edit_q >> 4);

`ifdef KEY_NUM_SIGN_EN
  assign final_commit_d = neg_q ? (~edit_q + DATA_W'(1)) : edit_q;
`else
  assign final_commit_d = edit_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ks_meta_q <= 1'b0;
      ks_sync_q <= 1'b0;
      ks_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      radix_q   <= 1'b0;
      edit_q    <= '0;
      final_q   <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      ks_meta_q <= key_state;
      ks_sync_q <= ks_meta_q;
      ks_prev_q <= ks_sync_q;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;

      if (key_event_w) begin
        unique case (state_q)
          ST_IDLE: begin
            unique case (key_class_w)
              KC_DIGIT: begin
                radix_q <= radix_dec;
                edit_q  <= DATA_W'(digit_w);
                cnt_q   <= C_ONE_CNT;
                state_q <= ST_ENTRY;
              end
              KC_ENTER: begin
                final_q <= '0;
                valid_q <= 1'b1;
                neg_q   <= 1'b0;
              end
              KC_BKSP, KC_ESC: begin
                neg_q <= 1'b0;
              end
`ifdef KEY_NUM_SIGN_EN
              KC_MINUS: begin
                neg_q <= 1'b1;
              end
`endif
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end

          ST_ENTRY: begin
            unique case (key_class_w)
              KC_DIGIT: begin
                if (cnt_q == C_MAX_CNT) begin
                  err_q <= 1'b1;
                end else begin
                  edit_q <= edit_append_d;
                  cnt_q  <= cnt_q + C_ONE_CNT;
                end
              end
              KC_BKSP: begin
                edit_q <= edit_bksp_d;
                cnt_q  <= cnt_q - C_ONE_CNT;
                if (cnt_q == C_ONE_CNT) begin
                  state_q <= ST_IDLE;
                end
              end
              KC_ENTER: begin
                final_q <= final_commit_d;
                valid_q <= 1'b1;
                edit_q  <= '0;
                cnt_q   <= '0;
                neg_q   <= 1'b0;
                state_q <= ST_IDLE;
              end
              KC_ESC: begin
                edit_q  <= '0;
                cnt_q   <= '0;
                neg_q   <= 1'b0;
                state_q <= ST_IDLE;
              end
              default: begin
                // ENTRY always holds >= 1 digit, so '-' is misplaced here
                err_q <= 1'b1;
              end
            endcase
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign edit_num  = edit_q;
  assign final_num = final_q;
  assign digit_cnt = cnt_q;
  assign num_valid = valid_q;
  assign err       = err_q;

`ifdef KEY_NUM_SIGN_EN
  assign neg = neg_q;
`else
  logic unused_neg;
  assign unused_neg = neg_q;
`endif

endmodule : key_num_entry
`default_nettype wire

// File: tb/tb_key_num_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_num_entry
// Description : Self-checking bench for key_num_entry. A table of key
//               releases with expected outputs is applied in a loop; the
//               expectation is queued when the key is driven and compared when
//               the DUT output updates. Hand sequences cover long holds,
//               asynchronous reset and the optional sign feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_num_entry;

  localparam int DATA_W     = 32;
  localparam int MAX_DIGITS = 8;
  localparam int CNT_W      = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              key_state;
  logic [7:0]        key_ascii;
  logic              radix_dec;
  logic [DATA_W-1:0] edit_num;
  logic [DATA_W-1:0] final_num;
  logic [CNT_W-1:0]  digit_cnt;
  logic              num_valid;
  logic              err;
`ifdef KEY_NUM_SIGN_EN
  logic              neg;
`endif

  key_num_entry #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_state (key_state),
    .key_ascii (key_ascii),
    .radix_dec (radix_dec),
    .edit_num  (edit_num),
    .final_num (final_num),
    .digit_cnt (digit_cnt),
    .num_valid (num_valid),
    .err       (err)
`ifdef KEY_NUM_SIGN_EN
    ,
    .neg       (neg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ascii;
    logic        rdx;
    logic [31:0] edit;
    logic [31:0] fin;
    logic [31:0] cnt;
    logic        valid;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          n_vec     = 0;
  int          n_miss    = 0;
  logic [31:0] last_edit = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Release one key and compare the outputs 3 clk after the pin falls
  task automatic press(input logic [7:0] a, input logic rdx, input int hold);
    vec_t e;
    @(negedge clk);
    key_ascii = a;
    radix_dec = rdx;
    key_state = 1'b1;
    repeat (hold) @(negedge clk);
    key_state = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("early_edit[%02h]", a), edit_num, last_edit);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard[%02h]: got empty queue, expected an entry", a);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("edit[%02h]",  a), edit_num,          e.edit);
      chk($sformatf("final[%02h]", a), final_num,         e.fin);
      chk($sformatf("cnt[%02h]",   a), 32'(digit_cnt),    e.cnt);
      chk($sformatf("valid[%02h]", a), 32'(num_valid),    32'(e.valid));
      chk($sformatf("err[%02h]",   a), 32'(err),          32'(e.err));
      last_edit = e.edit;
    end
    @(posedge clk);
    #1;
    chk($sformatf("pulse_clr[%02h]", a), {30'd0, num_valid, err}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic add(input logic [7:0] a, input logic r, input logic [31:0] ed,
                     input logic [31:0] fn, input logic [31:0] c, input logic v,
                     input logic er);
    vec_t t;
    t.ascii = a; t.rdx = r; t.edit = ed; t.fin = fn; t.cnt = c; t.valid = v; t.err = er;
    vecs.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_edit = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected run to end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    key_state = 1'b0;
    key_ascii = 8'h00;
    radix_dec = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_edit",  edit_num,          32'd0);
    chk("rst_final", final_num,         32'd0);
    chk("rst_cnt",   32'(digit_cnt),    32'd0);
    chk("rst_pulse", {30'd0, num_valid, err}, 32'd0);

    // Hex entry and commit
    add("1", 0, 32'h1,   32'h0,   1, 0, 0);
    add("a", 0, 32'h1A,  32'h0,   2, 0, 0);
    add("F", 0, 32'h1AF, 32'h0,   3, 0, 0);
    add(8'h0D, 0, 32'h0, 32'h1AF, 0, 1, 0);
    // Decimal entry with backspace
    add("1", 1, 32'd1,    32'h1AF, 1, 0, 0);
    add("2", 1, 32'd12,   32'h1AF, 2, 0, 0);
    add("3", 1, 32'd123,  32'h1AF, 3, 0, 0);
    add("4", 1, 32'd1234, 32'h1AF, 4, 0, 0);
    add(8'h08, 1, 32'd123,  32'h1AF, 3, 0, 0);
    add("9", 1, 32'd1239, 32'h1AF, 4, 0, 0);
    add(8'h0D, 1, 32'd0,  32'd1239, 0, 1, 0);
    add("b", 1, 32'd0,    32'd1239, 0, 0, 1);
    // Digit limit then escape
    add("7", 0, 32'h7,        32'd1239, 1, 0, 0);
    add("7", 0, 32'h77,       32'd1239, 2, 0, 0);
    add("7", 0, 32'h777,      32'd1239, 3, 0, 0);
    add("7", 0, 32'h7777,     32'd1239, 4, 0, 0);
    add("7", 0, 32'h77777,    32'd1239, 5, 0, 0);
    add("7", 0, 32'h777777,   32'd1239, 6, 0, 0);
    add("7", 0, 32'h7777777,  32'd1239, 7, 0, 0);
    add("7", 0, 32'h77777777, 32'd1239, 8, 0, 0);
    add("7", 0, 32'h77777777, 32'd1239, 8, 0, 1);
    add(8'h1B, 0, 32'h0,      32'd1239, 0, 0, 0);
    // IDLE no-ops and invalid codes
    add(8'h08, 0, 32'h0, 32'd1239, 0, 0, 0);
    add(8'h00, 0, 32'h0, 32'd1239, 0, 0, 1);
    add("G",   0, 32'h0, 32'd1239, 0, 0, 1);
    // Hex letter rejected in latched decimal, backspace to IDLE
    add("5",   1, 32'd5, 32'd1239, 1, 0, 0);
    add("c",   1, 32'd5, 32'd1239, 1, 0, 1);
    add(8'h08, 1, 32'd0, 32'd1239, 0, 0, 0);
    // Radix pin toggled mid-entry is ignored (hex latched)
    add("2",   0, 32'h2,   32'd1239, 1, 0, 0);
    add("3",   1, 32'h23,  32'd1239, 2, 0, 0);
    add("a",   1, 32'h23A, 32'd1239, 3, 0, 0);
    add(8'h0D, 1, 32'h0,   32'h23A,  0, 1, 0);
    // Enter in IDLE commits zero
    add(8'h0D, 0, 32'h0,   32'h0,    0, 1, 0);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      press(vecs[i].ascii, vecs[i].rdx, 3);
    end

    // Long hold gives exactly one event
    exp_q.push_back('{ascii: "5", rdx: 1'b0, edit: 32'h5, fin: 32'h0, cnt: 32'd1, valid: 1'b0, err: 1'b0});
    press("5", 1'b0, 50);
    repeat (10) @(posedge clk);
    #1;
    chk("hold_cnt",  32'(digit_cnt), 32'd1);
    chk("hold_edit", edit_num,       32'h5);
    exp_q.push_back('{ascii: 8'h1B, rdx: 1'b0, edit: 32'h0, fin: 32'h0, cnt: 32'd0, valid: 1'b0, err: 1'b0});
    press(8'h1B, 1'b0, 3);

    // Commit 9, then asynchronous reset in the middle of entering 0x12
    exp_q.push_back('{ascii: "9", rdx: 1'b0, edit: 32'h9, fin: 32'h0, cnt: 32'd1, valid: 1'b0, err: 1'b0});
    press("9", 1'b0, 3);
    exp_q.push_back('{ascii: 8'h0D, rdx: 1'b0, edit: 32'h0, fin: 32'h9, cnt: 32'd0, valid: 1'b1, err: 1'b0});
    press(8'h0D, 1'b0, 3);
    exp_q.push_back('{ascii: "1", rdx: 1'b0, edit: 32'h1, fin: 32'h9, cnt: 32'd1, valid: 1'b0, err: 1'b0});
    press("1", 1'b0, 3);
    exp_q.push_back('{ascii: "2", rdx: 1'b0, edit: 32'h12, fin: 32'h9, cnt: 32'd2, valid: 1'b0, err: 1'b0});
    press("2", 1'b0, 3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_edit",  edit_num,       32'd0);
    chk("arst_final", final_num,      32'd0);
    chk("arst_cnt",   32'(digit_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_edit = '0;
    exp_q.push_back('{ascii: 8'h0D, rdx: 1'b0, edit: 32'h0, fin: 32'h0, cnt: 32'd0, valid: 1'b1, err: 1'b0});
    press(8'h0D, 1'b0, 3);

`ifdef KEY_NUM_SIGN_EN
    exp_q.push_back('{ascii: 8'h2D, rdx: 1'b0, edit: 32'h0, fin: 32'h0, cnt: 32'd0, valid: 1'b0, err: 1'b0});
    press(8'h2D, 1'b0, 3);
    chk("neg_set", 32'(neg), 32'd1);
    exp_q.push_back('{ascii: "5", rdx: 1'b0, edit: 32'h5, fin: 32'h0, cnt: 32'd1, valid: 1'b0, err: 1'b0});
    press("5", 1'b0, 3);
    exp_q.push_back('{ascii: 8'h2D, rdx: 1'b0, edit: 32'h5, fin: 32'h0, cnt: 32'd1, valid: 1'b0, err: 1'b1});
    press(8'h2D, 1'b0, 3);
    exp_q.push_back('{ascii: 8'h0D, rdx: 1'b0, edit: 32'h0, fin: 32'hFFFF_FFFB, cnt: 32'd0, valid: 1'b1, err: 1'b0});
    press(8'h0D, 1'b0, 3);
    chk("neg_clr", 32'(neg), 32'd0);
`else
    exp_q.push_back('{ascii: 8'h2D, rdx: 1'b0, edit: 32'h0, fin: 32'h0, cnt: 32'd0, valid: 1'b0, err: 1'b1});
    press(8'h2D, 1'b0, 3);
`endif

    do_reset();
    #1;
    chk("end_final", final_num, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_key_num_entry
`default_nettype wire
